// File: rtl/imem_loader.sv
// imem_loader: receives a framed host byte stream and writes DATA_W-bit words
// into the instruction memory write port. The processor is held in reset
// (cpu_hold) until a frame completes without error.
//
// Frame: SYNC_BYTE, COUNT_HI, COUNT_LO, N words (MSB first), checksum byte.
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to compare the trailing byte
// against the XOR of all COUNT and DATA bytes. When the macro is undefined,
// the trailing byte is consumed and ignored, and no XOR register is built.
module imem_loader #(
    parameter int         ADDR_W         = 12,
    parameter int         DATA_W         = 32,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] load_address,
    output logic [DATA_W-1:0] load_data,
    output logic              load_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int          BYTES     = DATA_W / 8;
    localparam int          BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int          IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Largest legal word count is the full address space (2^ADDR_W words).
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                run_q;
    logic                xfer;
    logic                start;
    logic                timed;
    logic                timeout_hit;
    logic                too_big;
    logic                last_byte;
    logic                last_word;
    logic                csum_ok;
    logic [15:0]         n_field;
    logic [15:0]         remain_q;
    logic [7:0]          cnt_hi_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BIDX_W-1:0]   byte_idx_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [DATA_W-1:0]   word_next;

    // A byte moves only when both sides agree in the same cycle.
    assign xfer        = rx_valid && rx_ready;

    // IDLE, DONE and ERR all behave as "waiting for a frame"; only the
    // sync byte starts a load, everything else is dropped.
    assign start       = xfer && (rx_byte == SYNC_BYTE) &&
                         (state_q inside {IDLE, DONE, ERR});

    assign n_field     = {cnt_hi_q, rx_byte};
    assign too_big     = {17'd0, n_field} > MAX_WORDS;
    assign last_byte   = (byte_idx_q == BIDX_W'(BYTES - 1));
    // remain_q counts words still to be written, so 1 means this is the last.
    assign last_word   = (remain_q == 16'd1);

    // Only mid-frame states wait on the host; WRITE is internal and the
    // waiting states have no deadline.
    assign timed       = state_q inside {CNT_HI, CNT_LO, DATA, CHECK};
    assign timeout_hit = timed && !xfer &&
                         (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running XOR of COUNT and DATA bytes; restarted by every sync byte.
    always_ff @(posedge clock) begin
        if (start) begin
            csum_q <= 8'h00;
        end else if (xfer && (state_q inside {CNT_HI, CNT_LO, DATA})) begin
            csum_q <= csum_q ^ rx_byte;
        end
    end

    assign csum_ok = (rx_byte == csum_q);
`else
    // Trailing byte is consumed but carries no meaning in this build.
    assign csum_ok = 1'b1;
`endif

    // Word assembly: bytes arrive MSB first, so each new byte enters at the
    // bottom and older bytes move up. The final byte of a word is merged
    // combinationally so the write can happen one cycle after it arrives.
    generate
        if (BYTES > 1) begin : g_shift
            logic [DATA_W-9:0] word_q;

            // Holds the bytes of the current word received so far.
            always_ff @(posedge clock) begin
                if ((state_q == DATA) && xfer) begin
                    word_q <= word_next[DATA_W-9:0];
                end
            end

            assign word_next = {word_q, rx_byte};
        end else begin : g_single
            assign word_next = rx_byte;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (xfer) begin
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    if (too_big) begin
                        state_d = ERR;
                    end else if (n_field == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && last_byte) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = last_word ? CHECK : DATA;
            end
            CHECK: begin
                if (xfer) begin
                    state_d = csum_ok ? DONE : ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled host aborts the frame; only reachable in timed states
        // and only on cycles without a transfer.
        if (timeout_hit) begin
            state_d = ERR;
        end
    end

    // Handshake and write strobe decoded from the current state. The host
    // must hold its byte through WRITE because rx_ready drops there.
    always_comb begin
        rx_ready  = run_q && (state_q != WRITE);
        load_wren = (state_q == WRITE);
    end

    // Registered status outputs so cpu_hold, which feeds the processor
    // reset, cannot glitch on state decode. run_q keeps rx_ready low until
    // the first clock edge after reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q    <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            run_q    <= 1'b1;
            done     <= (state_d == DONE);
            error    <= (state_d == ERR);
            cpu_hold <= (state_d != DONE);
        end
    end

    // Frame bookkeeping: count capture, words remaining, word address,
    // byte position within the word and the inter-byte idle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_hi_q   <= 8'h00;
            remain_q   <= 16'd0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            idle_q     <= '0;
        end else begin
            if (start) begin
                addr_q     <= '0;
                byte_idx_q <= '0;
            end

            if ((state_q == CNT_HI) && xfer) begin
                cnt_hi_q <= rx_byte;
            end

            if ((state_q == CNT_LO) && xfer) begin
                remain_q <= n_field;
            end

            if ((state_q == DATA) && xfer) begin
                byte_idx_q <= last_byte ? '0 : byte_idx_q + BIDX_W'(1);
            end

            // The address wraps to 0 after a full-space load; nothing is
            // written afterwards because remain_q has reached zero.
            if (state_q == WRITE) begin
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - 16'd1;
            end

            if (timed && !xfer) begin
                idle_q <= idle_q + IDLE_W'(1);
            end else begin
                idle_q <= '0;
            end
        end
    end

    // Write port address/data: captured as the last byte of a word arrives,
    // presented during WRITE and held afterwards until the next word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_address <= '0;
            load_data    <= '0;
        end else if ((state_q == DATA) && xfer && last_byte) begin
            load_address <= addr_q;
            load_data    <= word_next;
        end
    end

endmodule
